// File: rtl/mac_tx_axi_buffer.sv
// AXI4-Lite loaded transmit packet buffer that feeds the tri-mode MAC user TX port.
// Software fills the word buffer, then a CTRL write streams ceil(len/4) words with sop/eop/ben framing.
module mac_tx_axi_buffer #(
    parameter int _dat_w_mac          = 32,
    parameter int _ben_w_mac          = 2,
    parameter int _addr_w_mem         = 9,
    parameter int C_S_AXI_ADDR_WIDTH  = 32,
    parameter int C_S_AXI_DATA_WIDTH  = 32
) (
    input  logic                            mac_clk_i,
    input  logic                            mac_rst_i,
    input  logic                            mac_txwa_i,
    output logic                            mac_txwr_o,
    output logic [_dat_w_mac-1:0]           mac_txd_o,
    output logic [_ben_w_mac-1:0]           mac_txben_o,
    output logic                            mac_txsop_o,
    output logic                            mac_txeop_o,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);

    localparam int DEPTH   = 1 << _addr_w_mem;
    localparam int LEN_W   = _addr_w_mem + 3;
    localparam int CNT_W   = _addr_w_mem + 1;
    localparam int WIDX_W  = C_S_AXI_ADDR_WIDTH - 2;
    localparam int LANES   = C_S_AXI_DATA_WIDTH / 8;

    localparam logic [31:0]       MAX_LEN     = 32'(DEPTH * 4);
    localparam logic [WIDX_W-1:0] CTRL_WIDX   = WIDX_W'(32'h800 >> 2);
    localparam logic [WIDX_W-1:0] STATUS_WIDX = WIDX_W'(32'h804 >> 2);
    localparam logic [1:0]        RESP_OKAY   = 2'b00;
    localparam logic [1:0]        RESP_SLVERR = 2'b10;

    if (_dat_w_mac != 32 || C_S_AXI_DATA_WIDTH != 32) begin : g_bad_dat_w
        $error("mac_tx_axi_buffer supports only 32-bit data");
    end
    if (_ben_w_mac != 2) begin : g_bad_ben_w
        $error("mac_tx_axi_buffer supports only a 2-bit byte enable");
    end

    typedef enum logic [1:0] {
        s_idle,
        s_load,
        s_send
    } state_t;

    state_t                     state_reg, state_next;
    logic [LEN_W-1:0]           len_reg;
    logic [_addr_w_mem-1:0]     ptr_reg;
    logic [CNT_W-1:0]           sent_reg;
    logic [31:0]                pkt_cnt_reg;
    logic                       txwr_reg, txsop_reg, txeop_reg;
    logic [_dat_w_mac-1:0]      txd_reg;
    logic [_ben_w_mac-1:0]      txben_reg;

    logic                       awready_reg, bvalid_reg;
    logic [1:0]                 bresp_reg;
    logic                       arready_reg, rvalid_reg, rsel_buf_reg;
    logic [1:0]                 rresp_reg;
    logic [C_S_AXI_DATA_WIDTH-1:0] reg_rdata_reg;

    logic [C_S_AXI_DATA_WIDTH-1:0] buf_a_data, buf_b_data;
    logic                       busy, send_now, b_en;
    logic [LEN_W-1:0]           len_plus3, len_m1;
    logic [CNT_W-1:0]           nwords;
    logic                       last_word;

    // ---------------- AXI write channel ----------------
    logic aw_go, wr_fire, wr_is_buf, wr_is_ctrl, wr_len_ok, buf_we, ctrl_start;

    assign aw_go      = S_AXI_AWVALID && S_AXI_WVALID && !awready_reg && !bvalid_reg;
    assign wr_fire    = awready_reg && S_AXI_AWVALID && S_AXI_WVALID;
    assign wr_is_buf  = (S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:_addr_w_mem+2] == '0);
    assign wr_is_ctrl = (S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2] == CTRL_WIDX);
    assign wr_len_ok  = (S_AXI_WDATA != '0) && (S_AXI_WDATA <= MAX_LEN);
    assign buf_we     = wr_fire && wr_is_buf && !busy;
    assign ctrl_start = wr_fire && wr_is_ctrl && !busy && wr_len_ok;

    always_ff @(posedge mac_clk_i) begin
        if (mac_rst_i) begin
            awready_reg <= 1'b0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
        end else begin
            awready_reg <= aw_go;
            if (wr_fire) begin
                bvalid_reg <= 1'b1;
                bresp_reg  <= (buf_we || ctrl_start) ? RESP_OKAY : RESP_SLVERR;
            end else if (bvalid_reg && S_AXI_BREADY) begin
                bvalid_reg <= 1'b0;
            end
        end
    end

    // ---------------- AXI read channel ----------------
    // The read handshake never lands on the same edge as a write, so the
    // AXI side of the buffer behaves as a single read/write port.
    logic ar_go, rd_fire, rd_is_buf, rd_is_ctrl, rd_is_status;

    assign ar_go        = S_AXI_ARVALID && !arready_reg && !rvalid_reg && !aw_go;
    assign rd_fire      = arready_reg && S_AXI_ARVALID;
    assign rd_is_buf    = (S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:_addr_w_mem+2] == '0);
    assign rd_is_ctrl   = (S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2] == CTRL_WIDX);
    assign rd_is_status = (S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2] == STATUS_WIDX);

    always_ff @(posedge mac_clk_i) begin
        if (mac_rst_i) begin
            arready_reg   <= 1'b0;
            rvalid_reg    <= 1'b0;
            rsel_buf_reg  <= 1'b0;
            rresp_reg     <= RESP_OKAY;
            reg_rdata_reg <= '0;
        end else begin
            arready_reg <= ar_go;
            if (rd_fire) begin
                rvalid_reg   <= 1'b1;
                rsel_buf_reg <= rd_is_buf;
                rresp_reg    <= (rd_is_buf || rd_is_ctrl || rd_is_status) ? RESP_OKAY : RESP_SLVERR;
                if (rd_is_ctrl)
                    reg_rdata_reg <= C_S_AXI_DATA_WIDTH'(len_reg);
                else if (rd_is_status)
                    reg_rdata_reg <= {pkt_cnt_reg[15:0], 15'b0, busy};
                else
                    reg_rdata_reg <= '0;
            end else if (rvalid_reg && S_AXI_RREADY) begin
                rvalid_reg <= 1'b0;
            end
        end
    end

    // ---------------- Packet buffer: one byte-wide RAM per lane ----------------
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi = gi + 1) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] a_q, b_q;

            always_ff @(posedge mac_clk_i) begin
                if (buf_we && S_AXI_WSTRB[gi])
                    lane_mem[S_AXI_AWADDR[_addr_w_mem+1:2]] <= S_AXI_WDATA[8*gi +: 8];
                if (rd_fire && rd_is_buf)
                    a_q <= lane_mem[S_AXI_ARADDR[_addr_w_mem+1:2]];
            end

            always_ff @(posedge mac_clk_i) begin
                if (b_en)
                    b_q <= lane_mem[ptr_reg];
            end

            assign buf_a_data[8*gi +: 8] = a_q;
            assign buf_b_data[8*gi +: 8] = b_q;
        end
    endgenerate

    // ---------------- TX state machine ----------------
    assign busy      = (state_reg != s_idle);
    assign len_plus3 = len_reg + LEN_W'(3);
    assign len_m1    = len_reg - LEN_W'(1);
    assign nwords    = len_plus3[LEN_W-1:2];
    assign last_word = (sent_reg == nwords - CNT_W'(1));

    always_ff @(posedge mac_clk_i) begin
        if (mac_rst_i)
            state_reg <= s_idle;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        send_now   = 1'b0;
        b_en       = 1'b0;
        case (state_reg)
            s_idle: begin
                if (ctrl_start)
                    state_next = s_load;
            end
            s_load: begin
                b_en       = 1'b1;
                state_next = s_send;
            end
            s_send: begin
                if (txeop_reg) begin
                    state_next = s_idle;
                end else if (mac_txwa_i && (sent_reg != nwords)) begin
                    send_now = 1'b1;
                    b_en     = 1'b1;
                end
            end
            default: state_next = s_idle;
        endcase
    end

    // The port-B output register is the holding register: it always carries
    // the word at ptr_reg-1, so a send consumes it and prefetches the next.
    always_ff @(posedge mac_clk_i) begin
        if (mac_rst_i) begin
            len_reg     <= '0;
            ptr_reg     <= '0;
            sent_reg    <= '0;
            pkt_cnt_reg <= '0;
            txwr_reg    <= 1'b0;
            txsop_reg   <= 1'b0;
            txeop_reg   <= 1'b0;
            txd_reg     <= '0;
            txben_reg   <= '0;
        end else begin
            if (ctrl_start) begin
                len_reg  <= S_AXI_WDATA[LEN_W-1:0];
                ptr_reg  <= '0;
                sent_reg <= '0;
            end
            if (state_reg == s_load)
                ptr_reg <= ptr_reg + 1'b1;
            txwr_reg  <= send_now;
            txsop_reg <= send_now && (sent_reg == '0);
            txeop_reg <= send_now && last_word;
            txben_reg <= (send_now && last_word) ? len_m1[_ben_w_mac-1:0] : '0;
            if (send_now) begin
                txd_reg  <= buf_b_data;
                sent_reg <= sent_reg + 1'b1;
                ptr_reg  <= ptr_reg + 1'b1;
            end
            if (state_reg == s_send && txeop_reg)
                pkt_cnt_reg <= pkt_cnt_reg + 32'd1;
        end
    end

    assign mac_txwr_o    = txwr_reg;
    assign mac_txsop_o   = txsop_reg;
    assign mac_txeop_o   = txeop_reg;
    assign mac_txd_o     = txd_reg;
    assign mac_txben_o   = txben_reg;

    assign S_AXI_AWREADY = awready_reg;
    assign S_AXI_WREADY  = awready_reg;
    assign S_AXI_BVALID  = bvalid_reg;
    assign S_AXI_BRESP   = bresp_reg;
    assign S_AXI_ARREADY = arready_reg;
    assign S_AXI_RVALID  = rvalid_reg;
    assign S_AXI_RRESP   = rresp_reg;
    assign S_AXI_RDATA   = rsel_buf_reg ? buf_a_data : reg_rdata_reg;

    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                           len_plus3[1:0], len_m1[LEN_W-1:_ben_w_mac]};

endmodule

// File: tb/tb_mac_tx_axi_buffer.sv
// Scoreboard bench for mac_tx_axi_buffer: stimulus queues expected MAC words and AXI
// responses, independent monitors pop and compare whenever the DUT presents them.
module tb_mac_tx_axi_buffer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        mac_txwa_i;
    logic        mac_txwr_o, mac_txsop_o, mac_txeop_o;
    logic [31:0] mac_txd_o;
    logic [1:0]  mac_txben_o;
    logic [31:0] S_AXI_AWADDR, S_AXI_WDATA, S_AXI_ARADDR, S_AXI_RDATA;
    logic [2:0]  S_AXI_AWPROT;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
    logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
    logic        S_AXI_RVALID, S_AXI_RREADY;

    mac_tx_axi_buffer dut (
        .mac_clk_i     (clk),
        .mac_rst_i     (rst),
        .mac_txwa_i    (mac_txwa_i),
        .mac_txwr_o    (mac_txwr_o),
        .mac_txd_o     (mac_txd_o),
        .mac_txben_o   (mac_txben_o),
        .mac_txsop_o   (mac_txsop_o),
        .mac_txeop_o   (mac_txeop_o),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY)
    );

    localparam logic [1:0] OK  = 2'b00;
    localparam logic [1:0] ERR = 2'b10;

    typedef struct {
        logic [31:0] d;
        logic        sop;
        logic        eop;
        logic [1:0]  ben;
    } mac_exp_t;
    typedef struct {
        logic [31:0] addr;
        logic [1:0]  resp;
    } b_exp_t;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
    } r_exp_t;

    mac_exp_t    mq[$];
    b_exp_t      bq[$];
    r_exp_t      rq[$];
    logic [31:0] model [512];
    int          total = 0;
    int          bad = 0;
    int          mac_seen = 0;
    logic        wa_q = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitors ----------------
    always @(posedge clk) wa_q = mac_txwa_i;

    always @(negedge clk) begin
        if (!rst) begin
            if (mac_txwr_o) begin
                mac_exp_t e;
                $display("mac word %0d d=%h sop=%b eop=%b ben=%b",
                         mac_seen, mac_txd_o, mac_txsop_o, mac_txeop_o, mac_txben_o);
                chk($sformatf("wa_before_wr%0d", mac_seen), 64'(wa_q), 64'd1);
                if (mq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_mac_wr actual=d%h_eop%b expected=no_write", mac_txd_o, mac_txeop_o);
                end else begin
                    e = mq.pop_front();
                    chk($sformatf("mac_word%0d", mac_seen),
                        64'({mac_txd_o, mac_txsop_o, mac_txeop_o, mac_txben_o}),
                        64'({e.d, e.sop, e.eop, e.ben}));
                end
                mac_seen++;
            end
            if (S_AXI_BVALID && S_AXI_BREADY) begin
                b_exp_t e;
                if (bq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_bresp actual=%b expected=none", S_AXI_BRESP);
                end else begin
                    e = bq.pop_front();
                    $display("axi write addr=%h bresp=%b", e.addr, S_AXI_BRESP);
                    chk($sformatf("bresp_%h", e.addr), 64'(S_AXI_BRESP), 64'(e.resp));
                end
            end
            if (S_AXI_RVALID && S_AXI_RREADY) begin
                r_exp_t e;
                if (rq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rdata actual=%h expected=none", S_AXI_RDATA);
                end else begin
                    e = rq.pop_front();
                    $display("axi read addr=%h rdata=%h rresp=%b", e.addr, S_AXI_RDATA, S_AXI_RRESP);
                    chk($sformatf("rd_%h", e.addr), 64'({S_AXI_RDATA, S_AXI_RRESP}), 64'({e.data, e.resp}));
                end
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] exp);
        b_exp_t e;
        bit     got = 0;
        e.addr = addr;
        e.resp = exp;
        bq.push_back(e);
        if (exp == OK && addr < 32'h800)
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[addr[10:2]][8*b +: 8] = data[8*b +: 8];
        S_AXI_AWADDR  = addr;
        S_AXI_WDATA   = data;
        S_AXI_WSTRB   = strb;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (S_AXI_AWREADY) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL aw_timeout addr=%h actual=no_awready expected=awready", addr);
        end
        @(posedge clk);
        #1;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] exp);
        r_exp_t e;
        bit     got = 0;
        e.addr = addr;
        e.data = data;
        e.resp = exp;
        rq.push_back(e);
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (S_AXI_ARREADY) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL ar_timeout addr=%h actual=no_arready expected=arready", addr);
        end
        @(posedge clk);
        #1;
        S_AXI_ARVALID = 1'b0;
    endtask

    task automatic push_frame(input int len);
        mac_exp_t e;
        int nw = (len + 3) / 4;
        for (int i = 0; i < nw; i++) begin
            e.d   = model[i];
            e.sop = (i == 0);
            e.eop = (i == nw - 1);
            e.ben = (i == nw - 1) ? 2'((len - 1) % 4) : 2'b00;
            mq.push_back(e);
        end
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (mq.size() == 0) break;
            @(negedge clk);
            #1;
        end
        chk("drain_left", 64'(mq.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        mac_exp_t e;
        int       base;
        bit       got;

        rst = 1'b1;
        mac_txwa_i = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b1; S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b1;
        for (int i = 0; i < 512; i++) model[i] = '0;

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("reset_mac_out", 64'({mac_txwr_o, mac_txsop_o, mac_txeop_o, mac_txben_o, mac_txd_o}), 64'd0);
        chk("reset_axi_out", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP,
                                  S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA}), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        axi_read(32'h804, 32'h0, OK);
        axi_read(32'h800, 32'h0, OK);

        // basic 6-byte frame, hand-computed words
        axi_write(32'h000, 32'h03020100, 4'hF, OK);
        axi_write(32'h004, 32'h07060504, 4'hF, OK);
        e = '{d: 32'h03020100, sop: 1'b1, eop: 1'b0, ben: 2'b00}; mq.push_back(e);
        e = '{d: 32'h07060504, sop: 1'b0, eop: 1'b1, ben: 2'b01}; mq.push_back(e);
        axi_write(32'h800, 32'd6, 4'hF, OK);
        drain(50);
        axi_read(32'h804, 32'h00010000, OK);
        axi_read(32'h800, 32'd6, OK);
        axi_read(32'h004, 32'h07060504, OK);

        // byte strobes
        axi_write(32'h008, 32'h11223344, 4'hF, OK);
        axi_write(32'h008, 32'hFFFFFFFF, 4'b0101, OK);
        axi_read(32'h008, 32'h11FF33FF, OK);

        // 1-byte frame
        axi_write(32'h000, 32'hDEADBEEF, 4'hF, OK);
        e = '{d: 32'hDEADBEEF, sop: 1'b1, eop: 1'b1, ben: 2'b00}; mq.push_back(e);
        axi_write(32'h800, 32'd1, 4'hF, OK);
        drain(50);
        axi_read(32'h804, 32'h00020000, OK);

        // 64-byte frame under wa toggling every 3 cycles
        for (int i = 0; i < 16; i++)
            axi_write(32'(4 * i), {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, 4'hF, OK);
        push_frame(64);
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    repeat (3) @(posedge clk);
                    #1 mac_txwa_i = ~mac_txwa_i;
                end
            end
            begin
                axi_write(32'h800, 32'd64, 4'hF, OK);
                axi_read(32'h804, 32'h00020001, OK);
                drain(400);
            end
        join
        mac_txwa_i = 1'b1;

        // writes refused while busy (wa held low keeps the frame pending)
        mac_txwa_i = 1'b0;
        push_frame(64);
        axi_write(32'h800, 32'd64, 4'hF, OK);
        axi_write(32'h000, 32'h55555555, 4'hF, ERR);
        axi_write(32'h800, 32'd8, 4'hF, ERR);
        axi_read(32'h804, 32'h00030001, OK);
        axi_read(32'h000, 32'h03020100, OK);
        mac_txwa_i = 1'b1;
        drain(200);
        axi_read(32'h800, 32'd64, OK);

        // refused writes while idle
        axi_write(32'h800, 32'd0, 4'hF, ERR);
        axi_write(32'h800, 32'd2049, 4'hF, ERR);
        axi_write(32'hC00, 32'h12345678, 4'hF, ERR);
        axi_write(32'h804, 32'h00000001, 4'hF, ERR);
        axi_read(32'hC00, 32'h0, ERR);
        repeat (10) @(posedge clk);
        #1;
        axi_read(32'h804, 32'h00040000, OK);
        axi_read(32'h000, 32'h03020100, OK);
        axi_read(32'h800, 32'd64, OK);

        // reset at the 5th word of a 32-word frame
        for (int i = 0; i < 32; i++)
            axi_write(32'(4 * i), 32'hC0DE0000 | 32'(i), 4'hF, OK);
        for (int i = 0; i < 5; i++) begin
            e = '{d: model[i], sop: (i == 0), eop: 1'b0, ben: 2'b00};
            mq.push_back(e);
        end
        base = mac_seen;
        axi_write(32'h800, 32'd128, 4'hF, OK);
        got = 0;
        for (int i = 0; i < 100; i++) begin
            if (mac_seen >= base + 5) begin
                got = 1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL fifth_word_timeout actual=%0d expected=%0d", mac_seen - base, 5);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_mac_out", 64'({mac_txwr_o, mac_txsop_o, mac_txeop_o, mac_txben_o, mac_txd_o}), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_left", 64'(mq.size()), 64'd0);
        axi_read(32'h804, 32'h0, OK);
        axi_read(32'h800, 32'h0, OK);
        push_frame(8);
        axi_write(32'h800, 32'd8, 4'hF, OK);
        drain(50);
        axi_read(32'h804, 32'h00010000, OK);

        // full 2048-byte buffer, then a short frame starting back at word 0
        for (int i = 0; i < 512; i++)
            axi_write(32'(4 * i), 32'hA5000000 ^ (32'(i) * 32'h00010003), 4'hF, OK);
        push_frame(2048);
        axi_write(32'h800, 32'd2048, 4'hF, OK);
        drain(2000);
        push_frame(4);
        axi_write(32'h800, 32'd4, 4'hF, OK);
        drain(50);
        axi_read(32'h804, 32'h00030000, OK);

        repeat (5) @(posedge clk);
        chk("end_mac_q", 64'(mq.size()), 64'd0);
        chk("end_b_q", 64'(bq.size()), 64'd0);
        chk("end_r_q", 64'(rq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
